// File: rtl/seq_lut_loader_pkg.sv
// Types shared by the LUT loader, its staging buffer and the sequencer: state
// encodings, the packed 29-bit LUT entry, and the entry packing helper.
package seq_lut_loader_pkg;

  localparam int LUT_W = 29;

  typedef enum logic [2:0] {
    RST          = 3'd0,
    IDLE         = 3'd1,
    PANEL_STABLE = 3'd2,
    RESET_ROW    = 3'd3,
    INTEGRATE    = 3'd4,
    SAMPLE       = 3'd5,
    CONVERT      = 3'd6,
    READOUT      = 3'd7
  } seq_state_t;

  typedef struct packed {
    logic        sof;
    logic        eof;
    logic [15:0] length;
    logic [7:0]  repeat_count;
    seq_state_t  next_state;
  } lut_entry_t;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_SETUP,
    LD_WRITE,
    LD_HOLD,
    LD_VERIFY,
    LD_RELEASE
  } ld_state_t;

  function automatic lut_entry_t pack_lut_entry(input logic [2:0]  next_state,
                                                input logic [7:0]  repeat_count,
                                                input logic [15:0] length,
                                                input logic        eof,
                                                input logic        sof);
    lut_entry_t e;
    e.sof          = sof;
    e.eof          = eof;
    e.length       = length;
    e.repeat_count = repeat_count;
    e.next_state   = seq_state_t'(next_state);
    return e;
  endfunction

endpackage

// File: rtl/seq_lut_loader_if.sv
// Host entry handshake: one sequence entry per valid&&ready transfer.
interface seq_lut_loader_if;
  logic        entry_valid_i;
  logic        entry_ready_o;
  logic [2:0]  entry_next_state_i;
  logic [7:0]  entry_repeat_i;
  logic [15:0] entry_length_i;
  logic        entry_eof_i;
  logic        entry_sof_i;

  modport master (
    output entry_valid_i, entry_next_state_i, entry_repeat_i,
           entry_length_i, entry_eof_i, entry_sof_i,
    input  entry_ready_o
  );

  modport slave (
    input  entry_valid_i, entry_next_state_i, entry_repeat_i,
           entry_length_i, entry_eof_i, entry_sof_i,
    output entry_ready_o
  );
endinterface

// File: rtl/seq_lut_loader_stage_buf.sv
// Staging buffer of DEPTH LUT entries: append on write, random read by index.
// Clear with a simultaneous write leaves just the new entry at slot 0.
module seq_lut_stage_buf
  import seq_lut_loader_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     clear,
  input  lut_entry_t               wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output lut_entry_t               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  lut_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_addr;

  assign wr_addr = clear ? '0 : count[AW-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        count <= '0;
    else if (clear) count <= wr_en ? CW'(1) : '0;
    else if (wr_en) count <= count + 1'b1;
  end

  assign rd_data = mem[rd_addr];
  assign full    = (count == CW'(DEPTH));

endmodule

// File: rtl/seq_lut_loader.sv
// Stages host LUT entries and bursts them into the sequencer while holding it
// in reset. Define SEQ_LUT_VERIFY_EN to read back and compare after the burst.
module seq_lut_loader
  import seq_lut_loader_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int RST_SETUP = 2,
  parameter int RST_HOLD  = 1
) (
  input  logic                   clk,
  input  logic                   reset_i,
  seq_lut_loader_if.slave        ent,
  input  logic                   commit_i,
  input  logic                   clear_i,
  output logic                   seq_reset_o,
  output logic                   lut_wen_o,
  output logic [LUT_W-1:0]       lut_write_data_o,
  output logic                   lut_rden_o,
  input  logic [LUT_W-1:0]       lut_read_data_i,
  output logic                   busy_o,
  output logic                   load_done_o,
  output logic                   error_o,
  output logic [$clog2(DEPTH):0] entry_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2((RST_SETUP > RST_HOLD ? RST_SETUP : RST_HOLD) + 1);

  ld_state_t     state;
  logic [TW-1:0] tmr;
  logic [CW-1:0] idx;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_addr;
  lut_entry_t    rd_data;
  logic          full, accept, buf_clear, commit_ok;

  assign ent.entry_ready_o = (state == LD_IDLE) && !full;
  assign accept            = ent.entry_valid_i && ent.entry_ready_o;
  // Commit beats clear; an entry accepted alongside commit counts toward the load.
  assign buf_clear         = (state == LD_IDLE) && clear_i && !commit_i;
  assign commit_ok         = (count != '0) || accept;
  assign entry_count_o     = count;

  seq_lut_stage_buf #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .rst     (reset_i),
    .wr_en   (accept),
    .clear   (buf_clear),
    .wr_data (pack_lut_entry(ent.entry_next_state_i, ent.entry_repeat_i,
                             ent.entry_length_i, ent.entry_eof_i, ent.entry_sof_i)),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .count   (count),
    .full    (full)
  );

`ifdef SEQ_LUT_VERIFY_EN
  logic [CW-1:0] chk_idx;
  logic          rd_vld_p1;
  assign rd_addr = (state == LD_VERIFY) ? chk_idx[AW-1:0] : idx[AW-1:0];
`else
  logic unused_rd_data;
  assign unused_rd_data = ^lut_read_data_i;
  assign lut_rden_o     = 1'b0;
  assign rd_addr        = idx[AW-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state            <= LD_IDLE;
      tmr              <= '0;
      idx              <= '0;
      seq_reset_o      <= 1'b0;
      lut_wen_o        <= 1'b0;
      lut_write_data_o <= '0;
      busy_o           <= 1'b0;
      load_done_o      <= 1'b0;
      error_o          <= 1'b0;
`ifdef SEQ_LUT_VERIFY_EN
      lut_rden_o       <= 1'b0;
      chk_idx          <= '0;
      rd_vld_p1        <= 1'b0;
`endif
    end else begin
      load_done_o <= 1'b0;
`ifdef SEQ_LUT_VERIFY_EN
      rd_vld_p1   <= lut_rden_o;
`endif
      case (state)
        LD_IDLE: begin
          if (commit_i) begin
            if (commit_ok) begin
              state       <= LD_SETUP;
              seq_reset_o <= 1'b1;
              busy_o      <= 1'b1;
              error_o     <= 1'b0;
              tmr         <= '0;
              idx         <= '0;
            end else begin
              error_o <= 1'b1;
            end
          end
        end
        LD_SETUP: begin
          if (tmr == TW'(RST_SETUP - 1)) begin
            state            <= LD_WRITE;
            lut_wen_o        <= 1'b1;
            lut_write_data_o <= rd_data;
            idx              <= idx + 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        // idx is the next entry to present; the burst ends once all are out.
        LD_WRITE: begin
          if (idx == count) begin
            state     <= LD_HOLD;
            lut_wen_o <= 1'b0;
            tmr       <= '0;
          end else begin
            lut_write_data_o <= rd_data;
            idx              <= idx + 1'b1;
          end
        end
        LD_HOLD: begin
          if (tmr == TW'(RST_HOLD - 1)) begin
`ifdef SEQ_LUT_VERIFY_EN
            state      <= LD_VERIFY;
            lut_rden_o <= 1'b1;
            idx        <= CW'(1);
            chk_idx    <= '0;
`else
            state       <= LD_RELEASE;
            seq_reset_o <= 1'b0;
            load_done_o <= 1'b1;
`endif
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
`ifdef SEQ_LUT_VERIFY_EN
        // idx counts read pulses issued; chk_idx the entry whose data returns now.
        LD_VERIFY: begin
          lut_rden_o <= (idx < count);
          if (idx < count) idx <= idx + 1'b1;
          if (rd_vld_p1) begin
            if (lut_read_data_i != rd_data) begin
              state      <= LD_IDLE;
              lut_rden_o <= 1'b0;
              busy_o     <= 1'b0;
              error_o    <= 1'b1;
            end else if (chk_idx == count - 1'b1) begin
              state       <= LD_RELEASE;
              lut_rden_o  <= 1'b0;
              seq_reset_o <= 1'b0;
              load_done_o <= 1'b1;
            end else begin
              chk_idx <= chk_idx + 1'b1;
            end
          end
        end
`endif
        LD_RELEASE: begin
          state  <= LD_IDLE;
          busy_o <= 1'b0;
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_lut_loader.sv
// Scoreboarded bench for seq_lut_loader: stimulus pushes expected LUT words,
// a negedge monitor pops and compares them on every lut_wen_o cycle.
`timescale 1ns/1ps
module tb_seq_lut_loader;
  import seq_lut_loader_pkg::*;

  localparam int DEPTH     = 8;
  localparam int RST_SETUP = 2;
  localparam int RST_HOLD  = 1;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          commit_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          seq_reset_o, lut_wen_o, lut_rden_o, busy_o, load_done_o, error_o;
  logic [28:0]   lut_write_data_o, lut_read_data_i;
  logic [CW-1:0] entry_count_o;

  seq_lut_loader_if ent_if();

  seq_lut_loader #(.DEPTH(DEPTH), .RST_SETUP(RST_SETUP), .RST_HOLD(RST_HOLD)) dut (
    .clk              (clk),
    .reset_i          (reset_i),
    .ent              (ent_if),
    .commit_i         (commit_i),
    .clear_i          (clear_i),
    .seq_reset_o      (seq_reset_o),
    .lut_wen_o        (lut_wen_o),
    .lut_write_data_o (lut_write_data_o),
    .lut_rden_o       (lut_rden_o),
    .lut_read_data_i  (lut_read_data_i),
    .busy_o           (busy_o),
    .load_done_o      (load_done_o),
    .error_o          (error_o),
    .entry_count_o    (entry_count_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [28:0] exp_q[$];
  bit          rden_seen = 1'b0;

  // Six-entry reference program with hand-packed words {sof,eof,len,rpt,ns}.
  logic [2:0]  t_ns  [6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd1};
  logic [7:0]  t_rpt [6] = '{8'd2, 8'd4, 8'd8, 8'd3, 8'd255, 8'd1};
  logic [15:0] t_len [6] = '{16'd50, 16'd100, 16'd1000, 16'hFFFF, 16'd7, 16'd20};
  logic        t_eof [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        t_sof [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [28:0] t_word[6] = '{29'h10019012, 29'h00032023, 29'h001F4044,
                             29'h07FFF81D, 29'h00003FFF, 29'h0800A009};

`ifdef SEQ_LUT_VERIFY_EN
  localparam bit VERIFY = 1'b1;
  logic [28:0] model_lut [8];
  int          wptr = 0;
  int          rptr = 0;
  logic        corrupt = 1'b0;
  initial lut_read_data_i = '0;
  always @(posedge clk) begin
    if (commit_i) begin
      wptr <= 0;
      rptr <= 0;
    end else begin
      if (lut_wen_o) begin
        model_lut[wptr[2:0]] <= lut_write_data_o;
        wptr <= wptr + 1;
      end
      if (lut_rden_o) begin
        lut_read_data_i <= model_lut[rptr[2:0]] ^ ((corrupt && rptr == 2) ? 29'h1 : 29'h0);
        rptr <= rptr + 1;
      end
    end
  end
`else
  localparam bit VERIFY = 1'b0;
  initial lut_read_data_i = '0;
`endif

  function automatic int lat(input int n);
    return 1 + RST_SETUP + n + RST_HOLD + (VERIFY ? n + 1 : 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented LUT word must match the head of the queue.
  initial forever begin
    @(negedge clk);
    if (lut_rden_o === 1'b1) rden_seen = 1'b1;
    if (lut_wen_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lut_word_unexpected: got 0x%0h, want no write", lut_write_data_o);
      end else begin
        check("lut_word", 32'(lut_write_data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic set_entry(input logic [2:0] ns, input logic [7:0] rpt, input logic [15:0] len,
                           input logic eof, input logic sof);
    ent_if.entry_next_state_i = ns;
    ent_if.entry_repeat_i     = rpt;
    ent_if.entry_length_i     = len;
    ent_if.entry_eof_i        = eof;
    ent_if.entry_sof_i        = sof;
  endtask

  // Holds valid until accepted or the bound expires; a refused entry stays offered.
  task automatic offer(input logic [2:0] ns, input logic [7:0] rpt, input logic [15:0] len,
                       input logic eof, input logic sof, input int bound, output bit acc);
    @(posedge clk); #1;
    set_entry(ns, rpt, len, eof, sof);
    ent_if.entry_valid_i = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < bound && !acc; i++) begin
      @(negedge clk);
      if (ent_if.entry_ready_o) acc = 1'b1;
      @(posedge clk); #1;
    end
    if (acc) ent_if.entry_valid_i = 1'b0;
  endtask

  task automatic load_six();
    bit acc;
    for (int i = 0; i < 6; i++) begin
      offer(t_ns[i], t_rpt[i], t_len[i], t_eof[i], t_sof[i], 5, acc);
      check("load_six_accept", 32'(acc), 32'd1);
    end
  endtask

  task automatic push_six();
    for (int i = 0; i < 6; i++) exp_q.push_back(t_word[i]);
  endtask

  // Cycle k=1 is the first cycle after the commit edge.
  task automatic run_load(input bit with_clear, input bit with_entry,
                          output int done_k, output int first_wen, output int wen_n, output int rst_n);
    @(posedge clk); #1;
    commit_i = 1'b1;
    clear_i  = with_clear;
    if (with_entry) ent_if.entry_valid_i = 1'b1;
    @(posedge clk); #1;
    commit_i = 1'b0;
    clear_i  = 1'b0;
    ent_if.entry_valid_i = 1'b0;
    done_k = -1; first_wen = -1; wen_n = 0; rst_n = 0;
    for (int k = 1; k <= 60 && done_k < 0; k++) begin
      @(negedge clk);
      if (lut_wen_o && first_wen < 0) first_wen = k;
      if (lut_wen_o) wen_n++;
      if (seq_reset_o) rst_n++;
      if (load_done_o) done_k = k;
    end
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
  endtask

  initial begin
    int  done_k, first_wen, wen_n, rst_n;
    bit  acc, any_rst, any_wen, any_busy;
    ent_if.entry_valid_i = 1'b0;
    set_entry(3'd0, 8'd0, 16'd0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ent_if.entry_ready_o), 32'd1);
    check("rst_seq_reset", 32'(seq_reset_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_count", 32'(entry_count_o), 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    check("rst_wen", 32'(lut_wen_o), 32'd0);
    check("rst_done", 32'(load_done_o), 32'd0);
    check("rst_rden", 32'(lut_rden_o), 32'd0);

    // Six-entry load with full timing profile.
    load_six();
    check("six_count", 32'(entry_count_o), 32'd6);
    push_six();
    run_load(1'b0, 1'b0, done_k, first_wen, wen_n, rst_n);
    check("six_first_wen", 32'(first_wen), 32'(1 + RST_SETUP));
    check("six_wen_cycles", 32'(wen_n), 32'd6);
    check("six_rst_cycles", 32'(rst_n), 32'(lat(6) - 1));
    check("six_done_cycle", 32'(done_k), 32'(lat(6)));
    check("six_error", 32'(error_o), 32'd0);

    // Re-commit with clear asserted: commit wins, buffer retained.
    push_six();
    run_load(1'b1, 1'b0, done_k, first_wen, wen_n, rst_n);
    check("recommit_done_cycle", 32'(done_k), 32'(lat(6)));
    check("recommit_count", 32'(entry_count_o), 32'd6);

    pulse_clear();
    check("clear_count", 32'(entry_count_o), 32'd0);

    // Commit on an empty buffer.
    @(posedge clk); #1 commit_i = 1'b1;
    @(posedge clk); #1 commit_i = 1'b0;
    any_rst = 0; any_wen = 0; any_busy = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      any_rst  |= seq_reset_o;
      any_wen  |= lut_wen_o;
      any_busy |= busy_o;
    end
    check("empty_error", 32'(error_o), 32'd1);
    check("empty_seq_reset", 32'(any_rst), 32'd0);
    check("empty_wen", 32'(any_wen), 32'd0);
    check("empty_busy", 32'(any_busy), 32'd0);

    // Fill to DEPTH, ninth entry is held off until space appears.
    for (int i = 0; i < DEPTH; i++) begin
      offer(3'(i), 8'(i), 16'(i * 3), 1'b0, 1'b0, 5, acc);
      check("fill_accept", 32'(acc), 32'd1);
    end
    check("full_count", 32'(entry_count_o), 32'(DEPTH));
    offer(3'd6, 8'h09, 16'h1234, 1'b1, 1'b1, 4, acc);
    check("ninth_held", 32'(acc), 32'd0);
    check("ninth_ready", 32'(ent_if.entry_ready_o), 32'd0);
    check("ninth_count", 32'(entry_count_o), 32'(DEPTH));
    clear_i = 1'b1;
    @(posedge clk); #1 clear_i = 1'b0;
    check("full_clear_count", 32'(entry_count_o), 32'd0);
    @(posedge clk); #1 ent_if.entry_valid_i = 1'b0;
    check("ninth_accepted_count", 32'(entry_count_o), 32'd1);

    // Entry accepted in the commit cycle joins the load as the last word.
    exp_q.push_back(29'h1891A04E);
    exp_q.push_back(29'h08000D28);
    set_entry(3'd0, 8'hA5, 16'h0001, 1'b1, 1'b0);
    run_load(1'b0, 1'b1, done_k, first_wen, wen_n, rst_n);
    check("commit_entry_wen_cycles", 32'(wen_n), 32'd2);
    check("commit_entry_done_cycle", 32'(done_k), 32'(lat(2)));
    check("commit_entry_count", 32'(entry_count_o), 32'd2);
    check("error_cleared", 32'(error_o), 32'd0);

    // Host reset on the third WRITE cycle.
    pulse_clear();
    load_six();
    for (int i = 0; i < 3; i++) exp_q.push_back(t_word[i]);
    @(posedge clk); #1 commit_i = 1'b1;
    @(posedge clk); #1 commit_i = 1'b0;
    repeat (RST_SETUP + 3) @(negedge clk);
    check("third_write_wen", 32'(lut_wen_o), 32'd1);
    reset_i = 1'b1;
    @(negedge clk);
    check("midreset_wen", 32'(lut_wen_o), 32'd0);
    check("midreset_seq_reset", 32'(seq_reset_o), 32'd0);
    check("midreset_busy", 32'(busy_o), 32'd0);
    check("midreset_count", 32'(entry_count_o), 32'd0);
    check("midreset_ready", 32'(ent_if.entry_ready_o), 32'd1);
    reset_i = 1'b0;

`ifdef SEQ_LUT_VERIFY_EN
    // Corrupted read-back of entry 2, then a clean re-commit.
    load_six();
    corrupt = 1'b1;
    push_six();
    run_load(1'b0, 1'b0, done_k, first_wen, wen_n, rst_n);
    check("verify_bad_no_done", 32'(done_k), 32'hFFFFFFFF);
    check("verify_bad_error", 32'(error_o), 32'd1);
    check("verify_bad_seq_reset", 32'(seq_reset_o), 32'd1);
    check("verify_bad_busy", 32'(busy_o), 32'd0);
    corrupt = 1'b0;
    push_six();
    run_load(1'b0, 1'b0, done_k, first_wen, wen_n, rst_n);
    check("verify_good_done_cycle", 32'(done_k), 32'(lat(6)));
    check("verify_good_error", 32'(error_o), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("rden_activity", 32'(rden_seen), 32'(VERIFY));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
